// File: rtl/sm3_digest_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sm3_digest_serializer_if
//  Purpose  : Bundles the digest-input and byte-output handshake signals of
//             the SM3 digest serializer.
//  Ports    : digest[0:255]  finished hash value, bit 0 is the MSB
//             digestValid    one-cycle strobe qualifying digest
//             digestReady    FIFO has room (registered)
//             oneByte[0:7]   output byte / ASCII character, bit 0 is the MSB
//             byteValid      oneByte is valid
//             byteReady      downstream accepts oneByte this cycle
//             lastByte       final byte/character of the current digest
//             overflow       sticky: a digest was offered while not ready
//  Modports : master - the surrounding system (drives digest, byteReady)
//             slave  - the serializer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface sm3_digest_serializer_if;
    logic [0:255] digest;
    logic         digestValid;
    logic         digestReady;
    logic [0:7]   oneByte;
    logic         byteValid;
    logic         byteReady;
    logic         lastByte;
    logic         overflow;

    modport master (
        output digest,
        output digestValid,
        output byteReady,
        input  digestReady,
        input  oneByte,
        input  byteValid,
        input  lastByte,
        input  overflow
    );

    modport slave (
        input  digest,
        input  digestValid,
        input  byteReady,
        output digestReady,
        output oneByte,
        output byteValid,
        output lastByte,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/sm3_digest_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : sm3_digest_serializer
//  Purpose  : Output stage of the SM3 hash core. Finished 256-bit digests are
//             queued in a DEPTH-entry FIFO and streamed out one byte per
//             cycle, most-significant byte first, over a valid/ready
//             interface.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous, active-high reset
//             bus  - sm3_digest_serializer_if.slave (digest input handshake,
//                    byte output handshake, sticky overflow flag)
//  Params   : DEPTH - digest FIFO entries, power of two in 1..8
//  Options  : SM3_HEX_ASCII_EN - when defined, every digest byte is sent as
//             two lowercase ASCII hex characters (high nibble first), giving
//             64 handshakes per digest instead of 32.
//  Revision : 1.0 - initial release
// ============================================================================
module sm3_digest_serializer #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sm3_digest_serializer_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef SM3_HEX_ASCII_EN
    localparam int BC_W  = 6;
`else
    localparam int BC_W  = 5;
`endif
    localparam logic [BC_W-1:0]  BC_LAST   = {BC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Digest FIFO
    // ------------------------------------------------------------------------
    logic [0:255]     mem_q [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             digest_ready_q;
    logic             overflow_q;

    // ------------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------------
    state_t           state_q;
    logic [0:255]     shift_q;
    logic [BC_W-1:0]  bcnt_q;
    logic [0:7]       byte_q;
    logic             bvalid_q;
    logic             last_q;

    logic             w_push;
    logic             w_pop;
    logic             w_hs;
    logic [0:255]     w_head;
    logic [BC_W-1:0]  w_bcnt_inc;
    logic [0:7]       w_first_out;
    logic [0:7]       w_next_out;
    logic             w_shift_adv;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Push is gated by the registered ready flag only, so an entry freed by a
    // pop in the same cycle cannot be claimed until the following cycle.
    assign w_push = bus.digestValid && digest_ready_q;
    // LOAD is only entered with a non-empty FIFO, and nothing but reset can
    // empty it in between, so LOAD always pops a valid entry.
    assign w_pop  = (state_q == ST_LOAD);
    assign w_hs   = bvalid_q && bus.byteReady;
    assign w_head = mem_q[rd_ptr_q];
    assign w_bcnt_inc = bcnt_q + 1'b1;

`ifdef SM3_HEX_ASCII_EN
    function automatic logic [0:7] to_hex(input logic [0:3] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h57 + {4'h0, n};   // 0x57 + 10 = 'a'
    endfunction

    // Even counter value -> high nibble of the byte at the top of the shift
    // register; odd -> low nibble. After an odd character the next one is the
    // high nibble of the following byte, which is still at [8:11] until the
    // shift happens on this same handshake.
    assign w_first_out = to_hex(w_head[0:3]);
    assign w_next_out  = bcnt_q[0] ? to_hex(shift_q[8:11]) : to_hex(shift_q[4:7]);
    assign w_shift_adv = bcnt_q[0];
`else
    assign w_first_out = w_head[0:7];
    assign w_next_out  = shift_q[8:15];
    assign w_shift_adv = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // FIFO pointer / occupancy next state
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            digest_ready_q <= 1'b1;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            digest_ready_q <= (count_d != CNT_FULL);
            if (bus.digestValid && !digest_ready_q) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.digest;
        end
    end

    // ------------------------------------------------------------------------
    // Output FSM with registered byte outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bcnt_q   <= '0;
            byte_q   <= '0;
            bvalid_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    shift_q  <= w_head;
                    bcnt_q   <= '0;
                    byte_q   <= w_first_out;
                    bvalid_q <= 1'b1;
                    last_q   <= 1'b0;
                    state_q  <= ST_SEND;
                end

                ST_SEND: begin
                    // Without a handshake every output register holds, which
                    // keeps oneByte/lastByte stable during a stall.
                    if (w_hs) begin
                        if (bcnt_q == BC_LAST) begin
                            bvalid_q <= 1'b0;
                            last_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            bcnt_q <= w_bcnt_inc;
                            byte_q <= w_next_out;
                            last_q <= (w_bcnt_inc == BC_LAST);
                            if (w_shift_adv) begin
                                shift_q <= shift_q << 8;
                            end
                        end
                    end
                end

                default: begin
                    state_q  <= ST_IDLE;
                    bvalid_q <= 1'b0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.digestReady = digest_ready_q;
    assign bus.overflow    = overflow_q;
    assign bus.oneByte     = byte_q;
    assign bus.byteValid   = bvalid_q;
    assign bus.lastByte    = last_q;

endmodule
`default_nettype wire

// File: tb/tb_sm3_digest_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm3_digest_serializer
//  Purpose  : Self-checking bench for sm3_digest_serializer (DEPTH = 2).
//             A byte-queue model expands every accepted digest into the
//             characters it must produce; a compare process checks each
//             handshake, stall stability and the overflow flag, and directed
//             scenarios pin literal values.
//  Options  : SM3_HEX_ASCII_EN selects the hex-character expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sm3_digest_serializer;

    localparam int DEPTH = 2;
    localparam logic [255:0] D_ABC   = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
    localparam logic [255:0] D_EMPTY = 256'h1ab21d8355cfa17f8e61194831e81a8f22bec8c728fefb747ed035eb5082aa2b;
    localparam logic [255:0] D_A     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] D_B     = 256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0;
    localparam logic [255:0] D_C     = 256'h5a5a5a5aa5a5a5a5deadbeefcafebabe0123456789abcdeffedcba9876543210;
`ifdef SM3_HEX_ASCII_EN
    localparam int NOUT = 64;
    localparam logic [7:0] ABC_F0 = 8'h36, ABC_F1 = 8'h36, ABC_L1 = 8'h65, ABC_L0 = 8'h30;
    localparam logic [7:0] EMPTY_F0 = 8'h31;
`else
    localparam int NOUT = 32;
    localparam logic [7:0] ABC_F0 = 8'h66, ABC_F1 = 8'hc7, ABC_L1 = 8'ha8, ABC_L0 = 8'he0;
    localparam logic [7:0] EMPTY_F0 = 8'h1a;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    sm3_digest_serializer_if bus();

    sm3_digest_serializer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_bad   = 0;
    int hs_seen = 0;
    bit ov_exp  = 1'b0;
    logic [7:0] exp_byte_q [$];
    bit         exp_last_q [$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: expected output characters of one accepted digest.
    function automatic void model_add(input logic [255:0] d);
`ifdef SM3_HEX_ASCII_EN
        string s;
        s = $sformatf("%064h", d);
        for (int i = 0; i < 64; i++) begin
            exp_byte_q.push_back(s[i]);
            exp_last_q.push_back(i == 63);
        end
`else
        for (int i = 0; i < 32; i++) begin
            exp_byte_q.push_back(d[255 - 8*i -: 8]);
            exp_last_q.push_back(i == 31);
        end
`endif
    endfunction

    // Compare process: sampled mid-cycle, away from the active edge.
    initial begin
        logic [7:0] prev_byte;
        bit         prev_last;
        bit         prev_stall;
        logic [7:0] eb;
        bit         el;
        prev_byte  = '0;
        prev_last  = 1'b0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else begin
                check("overflow", bus.overflow, ov_exp);
                if (prev_stall) begin
                    check("stall_valid", bus.byteValid, 1);
                    check("stall_byte", bus.oneByte, prev_byte);
                    check("stall_last", bus.lastByte, prev_last);
                end
                if (bus.byteValid !== 1'b1) begin
                    check("last_without_valid", bus.lastByte, 0);
                end
                if (bus.byteValid === 1'b1 && bus.byteReady === 1'b1) begin
                    if (exp_byte_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", bus.oneByte, $time);
                    end else begin
                        eb = exp_byte_q.pop_front();
                        el = exp_last_q.pop_front();
                        check("byte", bus.oneByte, eb);
                        check("lastByte", bus.lastByte, el);
                        hs_seen++;
                    end
                end
                prev_stall = (bus.byteValid === 1'b1) && (bus.byteReady !== 1'b1);
                prev_byte  = bus.oneByte;
                prev_last  = bus.lastByte;
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic push(input logic [255:0] d, input bit accept);
        bus.digest      = d;
        bus.digestValid = 1'b1;
        check("digestReady_at_push", bus.digestReady, accept);
        if (accept) model_add(d);
        @(posedge clk); #1;
        bus.digestValid = 1'b0;
        if (!accept) ov_exp = 1'b1;
    endtask

    task automatic do_reset();
        bus.byteReady   = 1'b0;
        bus.digestValid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        ov_exp = 1'b0;
        exp_byte_q.delete();
        exp_last_q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name, input bit random_ready);
        int n;
        n = 0;
        while ((exp_byte_q.size() != 0 || bus.byteValid === 1'b1) && n < 3000) begin
            bus.byteReady = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        bus.byteReady = 1'b0;
        check({name, "_remaining"}, exp_byte_q.size(), 0);
        check({name, "_valid_after"}, bus.byteValid, 0);
    endtask

    initial begin
        logic [7:0] rec [64];
        int nrec;
        int last_at;
        int guard;
        int base;

        bus.digest      = '0;
        bus.digestValid = 1'b0;
        bus.byteReady   = 1'b0;
        do_reset();

        // Reset state and idle behaviour
        for (int i = 0; i < 10; i++) begin
            check("idle_byteValid", bus.byteValid, 0);
            check("idle_digestReady", bus.digestReady, 1);
            check("idle_overflow", bus.overflow, 0);
            check("idle_oneByte", bus.oneByte, 0);
            @(posedge clk); #1;
        end

        // SM3("abc") with byteReady held high: latency, order, last flag
        bus.byteReady = 1'b1;
        push(D_ABC, 1'b1);
        check("abc_lat_k", bus.byteValid, 0);
        @(posedge clk); #1;
        check("abc_lat_k1", bus.byteValid, 0);
        @(posedge clk); #1;
        check("abc_lat_k2_valid", bus.byteValid, 1);
        check("abc_first", bus.oneByte, ABC_F0);
        nrec = 0;
        last_at = -1;
        guard = 0;
        while (bus.byteValid === 1'b1 && guard < 100) begin
            if (nrec < 64) rec[nrec] = bus.oneByte;
            if (bus.lastByte === 1'b1) last_at = nrec;
            nrec++;
            guard++;
            @(posedge clk); #1;
        end
        check("abc_count", nrec, NOUT);
        check("abc_second", rec[1], ABC_F1);
        check("abc_second_last", rec[NOUT-2], ABC_L1);
        check("abc_final", rec[NOUT-1], ABC_L0);
        check("abc_last_pos", last_at, NOUT - 1);
        bus.byteReady = 1'b0;
        check("abc_model_empty", exp_byte_q.size(), 0);

        // Same digest under random back-pressure
        push(D_ABC, 1'b1);
        drain("abc_random", 1'b1);

        // Three back-to-back pushes into DEPTH=2 with the output stalled
        do_reset();
        push(D_A, 1'b1);
        push(D_B, 1'b1);
        push(D_C, 1'b0);
        idle(5);
        check("ovf_sticky", bus.overflow, 1);
        drain("two_digests", 1'b0);
        idle(3);
        check("ovf_still_set", bus.overflow, 1);

        // Full FIFO while the last byte is accepted together with a new push
        do_reset();
        push(D_A, 1'b1);
        idle(3);
        push(D_B, 1'b1);
        push(D_C, 1'b1);
        check("full_ready_low", bus.digestReady, 0);
        bus.byteReady = 1'b1;
        guard = 0;
        while (!(bus.byteValid === 1'b1 && bus.lastByte === 1'b1) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("full_reached_last", bus.lastByte, 1);
        push(D_EMPTY, 1'b0);
        check("full_refused_ovf", bus.overflow, 1);
        drain("full_refused", 1'b0);

        // Reset in the middle of a transfer
        do_reset();
        bus.byteReady = 1'b1;
        push(D_C, 1'b1);
        base = hs_seen;
        guard = 0;
        while (hs_seen - base < 10 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_bytes_before_rst", hs_seen - base, 10);
        do_reset();
        check("mid_rst_valid", bus.byteValid, 0);
        check("mid_rst_ready", bus.digestReady, 1);
        check("mid_rst_ovf", bus.overflow, 0);
        bus.byteReady = 1'b1;
        idle(5);
        check("mid_no_partial", bus.byteValid, 0);
        push(D_EMPTY, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_new_first_valid", bus.byteValid, 1);
        check("mid_new_first", bus.oneByte, EMPTY_F0);
        drain("after_reset", 1'b0);

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
